// File: rtl/demux1_4_4b_reg_pkg.sv
// Shared widths and slot state encoding for the 1:4 registered demux.
// Used by demux1_4_4b_reg and demux_slot; DEMUX_CNT_EN enables the accept counters.
package demux1_4_4b_reg_pkg;

  localparam int DATA_W   = 4;
  localparam int SEL_W    = 2;
  localparam int NUM_DEST = 4;
  localparam int CNT_W    = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: captures data on load, presents it with valid until
// the consumer takes it. A same-cycle consume and load keeps the slot full.
module demux_slot
  import demux1_4_4b_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  slot_state_e state, state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // A load always wins, so a drain-and-refill in one cycle stays FULL.
  always_comb begin
    state_next = state;
    if (load)
      state_next = FULL;
    else if (state == FULL && ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= data;
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/demux1_4_4b_reg.sv
// 1:4 demux with a registered one-entry slot per destination and ready/valid
// handshakes. Define DEMUX_CNT_EN for saturating per-destination accept counters.
module demux1_4_4b_reg
  import demux1_4_4b_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  s,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] outA,
  output logic [DATA_W-1:0] outB,
  output logic [DATA_W-1:0] outC,
  output logic [DATA_W-1:0] outD,
  output logic              vldA,
  output logic              vldB,
  output logic              vldC,
  output logic              vldD,
  input  logic              rdyA,
  input  logic              rdyB,
  input  logic              rdyC,
  input  logic              rdyD
`ifdef DEMUX_CNT_EN
  ,output logic             cnt_sat
`endif
);

  logic [NUM_DEST-1:0] vld;
  logic [NUM_DEST-1:0] rdy;
  logic [NUM_DEST-1:0] load;
  logic [DATA_W-1:0]   dout [NUM_DEST];

  assign rdy = {rdyD, rdyC, rdyB, rdyA};

  // Ready ignores in_valid; a full slot still accepts if it drains this cycle.
  assign in_ready = !vld[s] || rdy[s];

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_slot
    assign load[i] = in_valid && in_ready && (s == SEL_W'(i));

    demux_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .data  (in),
      .ready (rdy[i]),
      .valid (vld[i]),
      .q     (dout[i])
    );
  end

  assign {vldD, vldC, vldB, vldA} = vld;
  assign outA = dout[0];
  assign outB = dout[1];
  assign outC = dout[2];
  assign outD = dout[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_DEST];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DEST; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++)
        if (load[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  always_comb begin
    cnt_sat = 1'b0;
    for (int i = 0; i < NUM_DEST; i++)
      if (cnt[i] == CNT_MAX) cnt_sat = 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux1_4_4b_reg.sv
// Scoreboard bench for demux1_4_4b_reg: the driver queues accepted words per
// destination, the monitor checks and pops them as they are consumed.
module tb_demux1_4_4b_reg;
  import demux1_4_4b_reg_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] outV [4];
  logic       vldA, vldB, vldC, vldD;
  logic [3:0] vldV;
  logic [3:0] rdyV;
`ifdef DEMUX_CNT_EN
  logic       cnt_sat;
  int         mcnt [4];
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] mfull;
  logic [3:0] sbq [4][$];

  assign vldV = {vldD, vldC, vldB, vldA};

  demux1_4_4b_reg dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .outA     (outV[0]),
    .outB     (outV[1]),
    .outC     (outV[2]),
    .outD     (outV[3]),
    .vldA     (vldA),
    .vldB     (vldB),
    .vldC     (vldC),
    .vldD     (vldD),
    .rdyA     (rdyV[0]),
    .rdyB     (rdyV[1]),
    .rdyC     (rdyV[2]),
    .rdyD     (rdyV[3])
`ifdef DEMUX_CNT_EN
    ,.cnt_sat (cnt_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after negedge; accepted words enter the scoreboard.
  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [3:0] d, input logic [3:0] r);
    @(negedge clk);
    #1;
    in_valid = v;
    s        = sel;
    in       = d;
    rdyV     = r;
    if (rst && v && (!mfull[sel] || r[sel]))
      sbq[sel].push_back(d);
  endtask

  // Monitor samples just before each posedge, seeing the values that edge will use.
  initial begin
    mfull = '0;
`ifdef DEMUX_CNT_EN
    for (int x = 0; x < 4; x++) mcnt[x] = 0;
`endif
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        for (int x = 0; x < 4; x++) begin
          checkOutput($sformatf("rst_vld%0d", x), int'(vldV[x]), 0);
          checkOutput($sformatf("rst_out%0d", x), int'(outV[x]), 0);
          sbq[x].delete();
        end
        mfull = '0;
`ifdef DEMUX_CNT_EN
        for (int x = 0; x < 4; x++) mcnt[x] = 0;
`endif
      end else begin
        logic       acc;
        logic [3:0] fnext;
        acc = in_valid && (!mfull[s] || rdyV[s]);
        checkOutput("in_ready", int'(in_ready), int'(!mfull[s] || rdyV[s]));
`ifdef DEMUX_CNT_EN
        begin
          logic sat;
          sat = 1'b0;
          for (int x = 0; x < 4; x++) if (mcnt[x] == 255) sat = 1'b1;
          checkOutput("cnt_sat", int'(cnt_sat), int'(sat));
        end
        if (acc && mcnt[s] < 255) mcnt[s]++;
`endif
        fnext = mfull;
        for (int x = 0; x < 4; x++) begin
          checkOutput($sformatf("vld%0d", x), int'(vldV[x]), int'(mfull[x]));
          if (mfull[x]) begin
            if (sbq[x].size() == 0)
              checkOutput($sformatf("sb_underflow%0d", x), 1, 0);
            else begin
              checkOutput($sformatf("out%0d", x), int'(outV[x]), int'(sbq[x][0]));
              if (rdyV[x]) void'(sbq[x].pop_front());
            end
            if (rdyV[x]) fnext[x] = 1'b0;
          end
          if (acc && s == 2'(x)) fnext[x] = 1'b1;
        end
        mfull = fnext;
      end
    end
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    in       = 4'hF;
    s        = 2'd0;
    rdyV     = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 2'(k), 4'h0, 4'b0000);
      #3;
      checkOutput("ready_after_rst", int'(in_ready), 1);
    end

    // Single route to C, then back-pressure until rdyC.
    applyStimulus(1'b1, 2'd2, 4'b1010, 4'b0000);
    #3; checkOutput("c_first_ready", int'(in_ready), 1);
    applyStimulus(1'b1, 2'd2, 4'b0110, 4'b0000);
    #3; checkOutput("c_blocked", int'(in_ready), 0);
    checkOutput("c_out", int'(outV[2]), 4'b1010);
    checkOutput("c_vld", int'(vldV), 4'b0100);
    applyStimulus(1'b1, 2'd2, 4'b0110, 4'b0100);
    #3; checkOutput("c_passthru", int'(in_ready), 1);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    #3; checkOutput("c_out2", int'(outV[2]), 4'b0110);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0100);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    #3; checkOutput("c_drained", int'(vldV[2]), 0);

    // Pass-through on B.
    applyStimulus(1'b1, 2'd1, 4'b1000, 4'b0000);
    applyStimulus(1'b1, 2'd1, 4'b0101, 4'b0010);
    #3; checkOutput("b_passthru", int'(in_ready), 1);
    checkOutput("b_old", int'(outV[1]), 4'b1000);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    #3; checkOutput("b_new", int'(outV[1]), 4'b0101);
    checkOutput("b_vld", int'(vldV[1]), 1);

    // Stalled A must not block D.
    applyStimulus(1'b1, 2'd0, 4'b0011, 4'b0000);
    applyStimulus(1'b1, 2'd3, 4'b0001, 4'b0000);
    #3; checkOutput("d_ready", int'(in_ready), 1);
    applyStimulus(1'b1, 2'd0, 4'b1111, 4'b0000);
    #3; checkOutput("a_blocked", int'(in_ready), 0);
    checkOutput("d_out", int'(outV[3]), 4'b0001);
    checkOutput("a_held", int'(outV[0]), 4'b0011);

    // Asynchronous reset mid-transfer discards held words.
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    #1; rst = 1'b0;
    #1; checkOutput("async_rst_vld", int'(vldV), 0);
    checkOutput("async_rst_outA", int'(outV[0]), 0);
    @(negedge clk);
    #2; rst = 1'b1;

    for (int i = 0; i < 1000; i++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

`ifdef DEMUX_CNT_EN
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 2'd0, 4'(i), 4'b0001);
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    #3; checkOutput("cnt_sat_final", int'(cnt_sat), 1);
`endif

    repeat (4) applyStimulus(1'b0, 2'd0, 4'h0, 4'b1111);
    @(negedge clk);
    #4;
    for (int x = 0; x < 4; x++)
      checkOutput($sformatf("sb_left%0d", x), sbq[x].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
